ca_correlator: RTL and testbench
================================

// Module: ca_correlator
// PURPOSE
//  Downstream consumer of the C/A code generator. Correlates a 1-bit sign-sampled IF input
//  against the local C/A chip stream, once per chip strobe. Integrates over one code epoch
//  (1023 chips) and dumps the signed sum through a valid/ready port. A SEARCH/CONFIRM/LOCK
//  FSM flags code-phase lock for the acquisition/tracking controller.
// PARAMETERS
//  CHIPS   1023  chips per integration epoch (>=2)
//  ACC_W   11    signed accumulator/result width; must hold +/-CHIPS
//  THRESH  300   |corr| >= THRESH counts as a hit (unsigned, ACC_W-1 bits)
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  rst         in   1      synchronous reset, active-low (0 = reset)
//  en          in   1      1 = process chip strobes; 0 = ignore strobes, all state holds
//  chip_stb    in   1      one-cycle pulse per chip; code/sample valid this cycle
//  code        in   1      local C/A chip from code generator
//  sample      in   1      IF sign bit (1 = positive)
//  corr        out  ACC_W  signed epoch correlation result
//  corr_valid  out  1      corr holds an unconsumed result
//  corr_ready  in   1      consumer accepts corr when corr_valid & corr_ready
//  chip_cnt    out  10     chips accumulated in current epoch, 0..CHIPS-1
//  lock        out  1      FSM in LOCK
//  overrun     out  1      sticky: a dump was dropped because corr was not consumed
// BEHAVIOUR
//  Reset (rst=0 at posedge): acc=0, chip_cnt=0, corr=0, corr_valid=0, overrun=0,
//   FSM=SEARCH, lock=0. Applies mid-epoch; partial sum is discarded.
//  Per strobe (en=1 & chip_stb=1): p = (code == sample) ? +1 : -1.
//   Not final chip (chip_cnt != CHIPS-1): acc <= acc + p; chip_cnt <= chip_cnt + 1.
//   Final chip (chip_cnt == CHIPS-1): dump value d = acc + p (sign-extended, ACC_W);
//   acc <= 0; chip_cnt <= 0.
//  chip_stb with en=0: ignored. en=0 never clears acc or chip_cnt.
//  Output port, evaluated at each posedge:
//   Dump, with corr_valid=0 or (corr_valid & corr_ready): corr <= d; corr_valid <= 1.
//   Dump, with corr_valid=1 & corr_ready=0: d is dropped; corr is unchanged; overrun <= 1.
//   No dump, with corr_valid & corr_ready: corr_valid <= 0; corr keeps its value.
//  Latency: corr/corr_valid update on the posedge after the final-chip strobe is sampled.
//  overrun clears only on reset.
//  FSM: updates at every dump, whether or not the dump was dropped.
//   Hit: |d| >= THRESH. |d| uses ACC_W-1 unsigned bits; the magnitude of -CHIPS is exact.
//   SEARCH : hit -> CONFIRM; miss -> SEARCH
//   CONFIRM: hit -> LOCK;    miss -> SEARCH
//   LOCK   : hit -> LOCK, miss_cnt <= 0
//            miss with miss_cnt=0 -> LOCK, miss_cnt <= 1
//            miss with miss_cnt=1 -> SEARCH
//   miss_cnt clears on reset and on any transition into LOCK.
//   lock = (state == LOCK), registered; lock changes in the same cycle as corr_valid rises.
//  Width rule: accumulate in ACC_W signed two's complement. No saturation is needed
//   because |acc| <= CHIPS.
// TESTING
//  1 sample=code for 1023 strobes, corr_ready=1 -> corr=+1023 and corr_valid=1 for 1 cycle,
//    one clk after the 1023rd strobe; chip_cnt=0.
//  2 sample=~code for 3 epochs -> corr=-1023 each epoch; FSM SEARCH->CONFIRM->LOCK;
//    lock=1 after the 2nd dump.
//  3 512 matching + 511 mismatching chips -> corr=+1; a miss; FSM stays SEARCH.
//  4 corr_ready=0 for 2 epochs, +1023 then -1023 -> corr stays +1023; overrun=1 after the
//    2nd dump; corr_ready=1 -> corr_valid drops the next cycle; overrun stays 1.
//  5 rst=0 for 1 clk at chip_cnt=500 -> all outputs at reset values; next dump requires
//    a fresh 1023 strobes. Also: en=0 with strobes toggling for 50 clks -> acc and
//    chip_cnt unchanged.
//  6 In LOCK: 1 miss epoch then 1 hit -> lock stays 1. Then 2 consecutive misses (corr=+1)
//    -> lock=0 after the 2nd miss dump; FSM=SEARCH.

Source files
------------

// File: rtl/ca_correlator.sv
// C/A code correlator: integrates sign-sampled IF against the local chip stream over one
// code epoch, dumps the signed sum through a valid/ready port and tracks code-phase lock.
module ca_correlator #(
  parameter int CHIPS  = 1023,
  parameter int ACC_W  = 11,
  parameter int THRESH = 300
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             chip_stb,
  input  logic             code,
  input  logic             sample,
  output logic [ACC_W-1:0] corr,
  output logic             corr_valid,
  input  logic             corr_ready,
  output logic [9:0]       chip_cnt,
  output logic             lock,
  output logic             overrun
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCK    = 2'd2
  } state_t;

  localparam logic [9:0]       LAST_CHIP = 10'(CHIPS - 1);
  localparam logic [ACC_W-2:0] THRESH_U  = (ACC_W-1)'(THRESH);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [9:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] corr_q, corr_d;
  logic             corr_valid_q, corr_valid_d;
  logic             overrun_q, overrun_d;
  logic             miss_cnt_q, miss_cnt_d;
  logic             lock_q, lock_d;
  state_t           state_q, state_d;

  logic             strobe;
  logic             last_chip;
  logic [ACC_W-1:0] p;
  logic [ACC_W-1:0] dump_val;
  logic [ACC_W-2:0] mag;
  logic             hit;

  // Epoch accumulation: each strobe adds +1 on agreement, -1 on disagreement.
  always_comb begin
    strobe    = en & chip_stb;
    last_chip = strobe && (cnt_q == LAST_CHIP);
    p         = (code == sample) ? ACC_W'(1) : {ACC_W{1'b1}};
    dump_val  = acc_q + p;
    // |d| fits ACC_W-1 bits since |d| <= CHIPS; negating -CHIPS is therefore exact.
    mag       = dump_val[ACC_W-1] ? (ACC_W-1)'(-dump_val) : dump_val[ACC_W-2:0];
    hit       = (mag >= THRESH_U);

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (strobe) begin
      if (last_chip) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = dump_val;
        cnt_d = cnt_q + 10'd1;
      end
    end
  end

  always_comb begin
    corr_d       = corr_q;
    corr_valid_d = corr_valid_q;
    overrun_d    = overrun_q;
    if (last_chip) begin
      if (!corr_valid_q || corr_ready) begin
        corr_d       = dump_val;
        corr_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (corr_valid_q && corr_ready) begin
      corr_valid_d = 1'b0;
    end
  end

  // Lock FSM advances on every dump, including dumps the output port had to drop.
  always_comb begin
    state_d    = state_q;
    miss_cnt_d = miss_cnt_q;
    if (last_chip) begin
      case (state_q)
        SEARCH: begin
          if (hit) state_d = CONFIRM;
        end
        CONFIRM: begin
          if (hit) begin
            state_d    = LOCK;
            miss_cnt_d = 1'b0;
          end else begin
            state_d = SEARCH;
          end
        end
        LOCK: begin
          if (hit) begin
            miss_cnt_d = 1'b0;
          end else if (!miss_cnt_q) begin
            miss_cnt_d = 1'b1;
          end else begin
            state_d    = SEARCH;
            miss_cnt_d = 1'b0;
          end
        end
        default: begin
          state_d    = SEARCH;
          miss_cnt_d = 1'b0;
        end
      endcase
    end
    lock_d = (state_d == LOCK);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      corr_q       <= '0;
      corr_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      miss_cnt_q   <= 1'b0;
      lock_q       <= 1'b0;
      state_q      <= SEARCH;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      corr_q       <= corr_d;
      corr_valid_q <= corr_valid_d;
      overrun_q    <= overrun_d;
      miss_cnt_q   <= miss_cnt_d;
      lock_q       <= lock_d;
      state_q      <= state_d;
    end
  end

  assign corr       = corr_q;
  assign corr_valid = corr_valid_q;
  assign chip_cnt   = cnt_q;
  assign lock       = lock_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ca_correlator.sv
// Randomised scoreboard bench for ca_correlator: an epoch-level reference model predicts each
// presented result; a monitor pops and compares whenever a new result appears on the port.
module tb_ca_correlator;

  localparam int CHIPS  = 1023;
  localparam int ACC_W  = 11;
  localparam int THRESH = 300;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             chip_stb = 1'b0;
  logic             code = 1'b0;
  logic             sample = 1'b0;
  logic [ACC_W-1:0] corr;
  logic             corr_valid;
  logic             corr_ready = 1'b0;
  logic [9:0]       chip_cnt;
  logic             lock;
  logic             overrun;

  ca_correlator #(.CHIPS(CHIPS), .ACC_W(ACC_W), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .en(en), .chip_stb(chip_stb), .code(code), .sample(sample),
    .corr(corr), .corr_valid(corr_valid), .corr_ready(corr_ready),
    .chip_cnt(chip_cnt), .lock(lock), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int corr;
    int lock;
    int over;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model: epoch-level view (count matches, sum = 2*matches - CHIPS).
  int m_cnt = 0;
  int m_matches = 0;
  int m_valid = 0;
  int m_corr = 0;
  int m_over = 0;
  int m_locked_state = 0;  // 0 searching, 1 one hit seen, 2 locked
  int m_misses = 0;
  int m_dumps = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic void modelEpochEnd(input int d);
    int mag;
    bit hit;
    mag = (d < 0) ? -d : d;
    hit = (mag >= THRESH);
    if (m_locked_state == 2) begin
      if (hit) m_misses = 0;
      else if (m_misses == 0) m_misses = 1;
      else m_locked_state = 0;
    end else if (hit) begin
      m_locked_state++;
      if (m_locked_state == 2) m_misses = 0;
    end else begin
      m_locked_state = 0;
    end
  endfunction

  task automatic applyStimulus(input logic st, input logic c, input logic s,
                               input logic rdy, input logic e);
    bit dump;
    int d;
    @(negedge clk);
    rst = 1'b1;
    chip_stb = st;
    code = c;
    sample = s;
    corr_ready = rdy;
    en = e;
    dump = 0;
    d = 0;
    if (e && st) begin
      if (c == s) m_matches++;
      m_cnt++;
      if (m_cnt == CHIPS) begin
        dump = 1;
        d = 2 * m_matches - CHIPS;
        m_cnt = 0;
        m_matches = 0;
        m_dumps++;
      end
    end
    if (dump) begin
      modelEpochEnd(d);
      if (m_valid == 0 || rdy) begin
        m_valid = 1;
        m_corr = d;
        sb_q.push_back('{corr: d, lock: (m_locked_state == 2) ? 1 : 0, over: m_over});
      end else begin
        m_over = 1;
      end
    end else if (m_valid != 0 && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic checkState(input string tag);
    @(posedge clk);
    #1;
    checkOutput({tag, ".chip_cnt"}, int'(chip_cnt), m_cnt);
    checkOutput({tag, ".corr_valid"}, int'(corr_valid), m_valid);
    checkOutput({tag, ".corr"}, int'($signed(corr)), m_corr);
    checkOutput({tag, ".lock"}, int'(lock), (m_locked_state == 2) ? 1 : 0);
    checkOutput({tag, ".overrun"}, int'(overrun), m_over);
  endtask

  task automatic runChips(input int n, input int match_pct, input logic rdy, input string tag);
    logic c;
    logic s;
    for (int i = 0; i < n; i++) begin
      c = 1'($urandom);
      s = (int'($urandom_range(99)) < match_pct) ? c : ~c;
      applyStimulus(1'b1, c, s, rdy, 1'b1);
    end
    checkState(tag);
  endtask

  task automatic resetDut(input string tag);
    @(negedge clk);
    rst = 1'b0;
    chip_stb = 1'b0;
    corr_ready = 1'b1;
    m_cnt = 0;
    m_matches = 0;
    m_valid = 0;
    m_corr = 0;
    m_over = 0;
    m_locked_state = 0;
    m_misses = 0;
    checkState(tag);
  endtask

  // Monitor: a new result is on the port when valid is high and either it was low before
  // or the previous result was consumed at this edge.
  initial begin
    int valid_prev;
    exp_t e;
    valid_prev = 0;
    forever begin
      @(posedge clk);
      #1;
      if (corr_valid && (valid_prev == 0 || corr_ready)) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_result", int'($signed(corr)), 0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("sb.corr", int'($signed(corr)), e.corr);
          checkOutput("sb.lock", int'(lock), e.lock);
          checkOutput("sb.overrun", int'(overrun), e.over);
        end
      end
      valid_prev = int'(corr_valid);
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d dumps, expected completion", m_dumps);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int target;
    int budget;
    int pct;
    resetDut("reset");

    // Full-match epoch, then the result must drop after one cycle with ready high.
    runChips(CHIPS, 100, 1'b1, "all_match");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkState("all_match_drop");

    // Three inverted epochs from a fresh SEARCH state.
    resetDut("reset2");
    for (int k = 0; k < 3; k++) runChips(CHIPS, 0, 1'b1, "inverted");

    // Near-zero correlation is a miss.
    resetDut("reset3");
    runChips(512, 100, 1'b1, "half_a");
    runChips(511, 0, 1'b1, "plus_one");

    // Backpressure: second dump is dropped and overrun sticks.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    runChips(CHIPS, 100, 1'b0, "bp_first");
    runChips(CHIPS, 0, 1'b0, "bp_dropped");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkState("bp_release");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkState("bp_after");

    // Reset mid-epoch, then en=0 must freeze progress.
    runChips(500, 50, 1'b1, "mid_epoch");
    resetDut("reset_mid");
    runChips(100, 100, 1'b1, "pre_hold");
    for (int i = 0; i < 50; i++) applyStimulus(1'(i % 2), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
    checkState("en_hold");
    runChips(CHIPS - 100, 100, 1'b1, "post_hold");

    // Lock retention: one miss tolerated, two consecutive misses drop lock.
    resetDut("reset_lock");
    runChips(CHIPS, 100, 1'b1, "lk_hit1");
    runChips(CHIPS, 0, 1'b1, "lk_hit2");
    runChips(512, 100, 1'b1, "lk_m1a");
    runChips(511, 0, 1'b1, "lk_miss1");
    runChips(CHIPS, 100, 1'b1, "lk_hit3");
    runChips(512, 100, 1'b1, "lk_m2a");
    runChips(511, 0, 1'b1, "lk_miss2");
    runChips(512, 100, 1'b1, "lk_m3a");
    runChips(511, 0, 1'b1, "lk_miss3");

    // Randomised epochs with gaps, enable drops and random backpressure.
    resetDut("reset_rand");
    target = m_dumps + 4;
    budget = 0;
    pct = int'($urandom_range(100));
    while (m_dumps < target && budget < 12000) begin
      logic c;
      c = 1'($urandom);
      if (m_cnt == 0 && $urandom_range(3) == 0) pct = int'($urandom_range(100));
      applyStimulus(1'($urandom_range(3) != 0), c,
                    (int'($urandom_range(99)) < pct) ? c : ~c,
                    1'($urandom), 1'($urandom_range(9) != 0));
      budget++;
    end
    checkOutput("rand_dumps", m_dumps, target);
    checkState("rand_end");

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkState("drain");
    checkOutput("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
